// File: rtl/mem_pkg.sv
// Shared constants and types for the two-port memory arbiter:
// virtual address windows, stack relocation offset, RAM width and FSM states.
package mem_pkg;

    localparam int unsigned PHYS_AW = 13;

    localparam logic [31:0] STACK_BASE   = 32'h7FFF_EFFC;
    localparam logic [31:0] STACK_LIMIT  = 32'h7FFF_FFFC;
    localparam logic [31:0] STACK_OFFSET = 32'h0000_0400;
    localparam logic [31:0] DATA_BASE    = 32'h1001_0000;
    localparam logic [31:0] DATA_LIMIT   = 32'h1001_1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
interface mem_arbiter_if #(
    parameter int DW  = 32,
    parameter int PAW = mem_pkg::PHYS_AW
) ();

    // Handshake: req_k with we_k/addr_k/wdata_k is held stable until the
    // one-cycle ack_k; err_k and rdata_k are valid from that ack cycle, and a
    // req_k still high in the cycle after ack_k counts as a new request.
    logic             req_0;
    logic             req_1;
    logic             we_0;
    logic             we_1;
    logic [31:0]      addr_0;
    logic [31:0]      addr_1;
    logic [DW-1:0]    wdata_0;
    logic [DW-1:0]    wdata_1;
    logic             ack_0;
    logic             ack_1;
    logic             err_0;
    logic             err_1;
    logic [DW-1:0]    rdata_0;
    logic [DW-1:0]    rdata_1;
    logic             mem_en;
    logic             mem_we;
    logic [PAW-1:0]   mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic             busy;
    logic [7:0]       err_count;
    mem_pkg::state_t  dbg_state;

    modport master (
        output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_rdata,
        input  ack_0, ack_1, err_0, err_1, rdata_0, rdata_1,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, err_count, dbg_state
    );

    modport slave (
        input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_rdata,
        output ack_0, ack_1, err_0, err_1, rdata_0, rdata_1,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, err_count, dbg_state
    );

endinterface

// File: rtl/addr_map.sv
// Virtual-to-physical decode: relocated stack window, direct data window,
// everything else (or any misaligned address) flagged invalid.
module addr_map
    import mem_pkg::*;
#(
    parameter int PAW = PHYS_AW
) (
    input  logic [31:0]    virt,
    output logic [PAW-1:0] phys,
    output logic           invalid
);

    logic in_stack;
    logic in_data;

    always_comb begin
        in_stack = (virt >= STACK_BASE) && (virt < STACK_LIMIT);
        in_data  = (virt >= DATA_BASE) && (virt < DATA_LIMIT);
        phys     = '0;
        if (in_stack) begin
            phys = PAW'(virt - STACK_BASE + STACK_OFFSET);
        end else if (in_data) begin
            phys = virt[PAW-1:0];
        end
        invalid = (virt[1:0] != 2'b00) || !(in_stack || in_data);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: alternating-priority grant, address translation and
// a fixed IDLE/ACCESS/RESP transaction against a synchronous-read RAM.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DW  = 32,
    parameter int PAW = PHYS_AW
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           winner_q, winner_d;
    logic           we_q, we_d;
    logic           inv_q, inv_d;
    logic           mem_en_q, mem_en_d;
    logic           mem_we_q, mem_we_d;
    logic [PAW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
    logic           ack_0_q, ack_0_d, ack_1_q, ack_1_d;
    logic           err_0_q, err_0_d, err_1_q, err_1_d;
    logic [DW-1:0]  rdata_0_q, rdata_0_d, rdata_1_q, rdata_1_d;
    logic [7:0]     err_count_q, err_count_d;

    logic           any_req;
    logic           grant;
    logic           sel_we;
    logic [31:0]    sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic [PAW-1:0] sel_phys;
    logic           sel_inv;

    always_comb begin
        any_req   = bus.req_0 | bus.req_1;
        // On a tie the requester not served last wins; a lone request wins outright.
        grant     = (bus.req_0 & bus.req_1) ? ~last_q : bus.req_1;
        sel_addr  = grant ? bus.addr_1  : bus.addr_0;
        sel_we    = grant ? bus.we_1    : bus.we_0;
        sel_wdata = grant ? bus.wdata_1 : bus.wdata_0;
    end

    addr_map #(.PAW(PAW)) u_addr_map (
        .virt    (sel_addr),
        .phys    (sel_phys),
        .invalid (sel_inv)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        winner_d    = winner_q;
        we_d        = we_q;
        inv_d       = inv_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ack_0_d     = 1'b0;
        ack_1_d     = 1'b0;
        err_0_d     = 1'b0;
        err_1_d     = 1'b0;
        rdata_0_d   = rdata_0_q;
        rdata_1_d   = rdata_1_q;
        err_count_d = err_count_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d  = ST_ACCESS;
                    last_d   = grant;
                    winner_d = grant;
                    we_d     = sel_we;
                    inv_d    = sel_inv;
                    // RAM strobes are registered here so they are visible during ACCESS.
                    if (!sel_inv) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_addr_d  = sel_phys;
                        mem_wdata_d = sel_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                ack_0_d = ~winner_q;
                ack_1_d = winner_q;
                err_0_d = ~winner_q & inv_q;
                err_1_d = winner_q & inv_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (inv_q && (err_count_q != 8'hFF)) begin
                    err_count_d = err_count_q + 8'd1;
                end
                // RAM data arrives in RESP; it is bypassed to rdata and captured.
                if (!inv_q && !we_q) begin
                    if (winner_q) begin
                        rdata_1_d = bus.mem_rdata;
                    end else begin
                        rdata_0_d = bus.mem_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            winner_q    <= 1'b0;
            we_q        <= 1'b0;
            inv_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack_0_q     <= 1'b0;
            ack_1_q     <= 1'b0;
            err_0_q     <= 1'b0;
            err_1_q     <= 1'b0;
            rdata_0_q   <= '0;
            rdata_1_q   <= '0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            winner_q    <= winner_d;
            we_q        <= we_d;
            inv_q       <= inv_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack_0_q     <= ack_0_d;
            ack_1_q     <= ack_1_d;
            err_0_q     <= err_0_d;
            err_1_q     <= err_1_d;
            rdata_0_q   <= rdata_0_d;
            rdata_1_q   <= rdata_1_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ack_0     = ack_0_q;
    assign bus.ack_1     = ack_1_q;
    assign bus.err_0     = err_0_q;
    assign bus.err_1     = err_1_q;
    assign bus.rdata_0   = rdata_0_d;
    assign bus.rdata_1   = rdata_1_d;
    assign bus.err_count = err_count_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, address/data reference model and a
// response scoreboard, exercised by one task per scenario.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int DW  = 32;
    localparam int PAW = 13;
    localparam int SBW = DW + 2;   // {port, err, rdata}
    localparam int ACW = PAW + DW + 2; // {mem_en, mem_we, mem_addr, mem_wdata}

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [SBW-1:0] exp_q[$];
    logic [DW-1:0]  shadow [0:(1<<PAW)-1];
    bit             shadow_wr [0:(1<<PAW)-1];
    logic [DW-1:0]  ram [0:(1<<PAW)-1];
    bit             ram_wr [0:(1<<PAW)-1];
    logic [DW-1:0]  rd_exp [0:1];
    int             err_exp;

    mem_arbiter_if #(.DW(DW), .PAW(PAW)) bus ();

    mem_arbiter #(.DW(DW), .PAW(PAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM and reference model ----------------
    function automatic logic [DW-1:0] init_pat(input logic [PAW-1:0] p);
        return 32'h5A00_0000 + {19'd0, p} * 32'd3;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << PAW); i++) ram_wr[i] <= 1'b0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr]    <= bus.mem_wdata;
                ram_wr[bus.mem_addr] <= 1'b1;
            end
            bus.mem_rdata <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : init_pat(bus.mem_addr);
        end
    end

    function automatic logic exp_inv(input logic [31:0] a);
        logic in_win;
        in_win = (a >= 32'h7FFF_EFFC && a <= 32'h7FFF_FFF8) ||
                 (a >= 32'h1001_0000 && a <= 32'h1001_0FFC);
        return !in_win || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [PAW-1:0] exp_phys(input logic [31:0] a);
        if (a[31:16] == 16'h7FFF) return PAW'(a - 32'h7FFF_EBFC);
        return a[PAW-1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < (1 << PAW); i++) shadow_wr[i] = 1'b0;
        rd_exp[0] = '0;
        rd_exp[1] = '0;
        err_exp   = 0;
        exp_q.delete();
    endtask

    task automatic model_txn(input int port, input logic we, input logic [31:0] a,
                             input logic [DW-1:0] wd);
        logic           inv;
        logic [PAW-1:0] ph;
        inv = exp_inv(a);
        ph  = exp_phys(a);
        if (inv) begin
            if (err_exp < 255) err_exp++;
        end else if (we) begin
            shadow[ph]    = wd;
            shadow_wr[ph] = 1'b1;
        end else begin
            rd_exp[port] = shadow_wr[ph] ? shadow[ph] : init_pat(ph);
        end
        exp_q.push_back({port[0], inv, rd_exp[port]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.req_0 = 1'b0; bus.we_0 = 1'b0; bus.addr_0 = '0; bus.wdata_0 = '0;
        bus.req_1 = 1'b0; bus.we_1 = 1'b0; bus.addr_1 = '0; bus.wdata_1 = '0;
    endtask

    task automatic drive_req(input int port, input logic we, input logic [31:0] a,
                             input logic [DW-1:0] wd);
        if (port == 0) begin
            bus.we_0 = we; bus.addr_0 = a; bus.wdata_0 = wd; bus.req_0 = 1'b1;
        end else begin
            bus.we_1 = we; bus.addr_1 = a; bus.wdata_1 = wd; bus.req_1 = 1'b1;
        end
    endtask

    task automatic drop_req(input int port);
        if (port == 0) bus.req_0 = 1'b0;
        else bus.req_1 = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Issues one request and records the RAM strobes one cycle later and the ack.
    task automatic run_txn(input int port, input logic we, input logic [31:0] a,
                           input logic [DW-1:0] wd, output logic [ACW-1:0] acc,
                           output int lat, output logic oth, output logic er,
                           output logic [DW-1:0] rd);
        drive_req(port, we, a, wd);
        lat = 0; acc = '0; oth = 1'b0; er = 1'b0; rd = '0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 2) acc = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
            if (port == 0 && bus.ack_0 === 1'b1) begin
                lat = c; er = bus.err_0; rd = bus.rdata_0; oth = bus.ack_1;
            end
            if (port == 1 && bus.ack_1 === 1'b1) begin
                lat = c; er = bus.err_1; rd = bus.rdata_1; oth = bus.ack_0;
            end
        end
        @(posedge clk);
        #1;
        drop_req(port);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.busy, bus.mem_en, bus.mem_we, bus.ack_0, bus.ack_1, bus.err_0, bus.err_1} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.busy, bus.mem_en, bus.mem_we, bus.ack_0, bus.ack_1, bus.err_0, bus.err_1});
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.rdata_0, bus.rdata_1} !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected all zero",
                     bus.mem_addr, bus.mem_wdata, bus.rdata_0, bus.rdata_1);
        end
        total++;
        if (bus.err_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_err_count: got %0d expected 0", bus.err_count);
        end
        total++;
        if (bus.dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, ST_IDLE);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_read();
        logic [ACW-1:0] acc; int lat; logic oth, er; logic [DW-1:0] rd; logic [SBW-1:0] exp_v;
        model_txn(0, 1'b0, 32'h1001_0010, '0);
        run_txn(0, 1'b0, 32'h1001_0010, '0, acc, lat, oth, er, rd);
        exp_v = exp_q.pop_front();
        total++;
        if (acc !== {1'b1, 1'b0, 13'h0010, 32'h0}) begin
            bad++; $display("FAIL read_access: got %h expected %h", acc, {1'b1, 1'b0, 13'h0010, 32'h0});
        end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL read_latency: got %0d expected 3", lat); end
        total++;
        if ({1'b0, er, rd} !== exp_v) begin
            bad++; $display("FAIL read_resp: got %h expected %h", {1'b0, er, rd}, exp_v);
        end
        total++;
        if (oth !== 1'b0) begin bad++; $display("FAIL read_other_ack: got %b expected 0", oth); end
    endtask

    task automatic test_write();
        logic [ACW-1:0] acc; int lat; logic oth, er; logic [DW-1:0] rd; logic [SBW-1:0] exp_v;
        logic [31:0] wa [3];
        logic [DW-1:0] wv [3];
        model_txn(1, 1'b1, 32'h7FFF_EFFC, 32'hDEAD_BEEF);
        run_txn(1, 1'b1, 32'h7FFF_EFFC, 32'hDEAD_BEEF, acc, lat, oth, er, rd);
        exp_v = exp_q.pop_front();
        total++;
        if (acc !== {1'b1, 1'b1, 13'h0400, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL write_access: got %h expected %h", acc, {1'b1, 1'b1, 13'h0400, 32'hDEAD_BEEF});
        end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL write_latency: got %0d expected 3", lat); end
        total++;
        if ({1'b1, er, rd} !== exp_v) begin
            bad++; $display("FAIL write_resp: got %h expected %h", {1'b1, er, rd}, exp_v);
        end
        // Window edges: write from one port, read back from the other.
        wa[0] = 32'h7FFF_EFFC; wv[0] = 32'hDEAD_BEEF;
        wa[1] = 32'h7FFF_FFF8; wv[1] = 32'hCAFE_0013;
        wa[2] = 32'h1001_0FFC; wv[2] = 32'h0BAD_F00D;
        for (int i = 1; i < 3; i++) begin
            model_txn(0, 1'b1, wa[i], wv[i]);
            run_txn(0, 1'b1, wa[i], wv[i], acc, lat, oth, er, rd);
            exp_v = exp_q.pop_front();
            total++;
            if (acc !== {1'b1, 1'b1, exp_phys(wa[i]), wv[i]} || {1'b0, er, rd} !== exp_v) begin
                bad++; $display("FAIL edge_write: addr %h got %h/%h expected %h/%h",
                                wa[i], acc, {1'b0, er, rd}, {1'b1, 1'b1, exp_phys(wa[i]), wv[i]}, exp_v);
            end
        end
        for (int i = 0; i < 3; i++) begin
            model_txn(i % 2, 1'b0, wa[i], '0);
            run_txn(i % 2, 1'b0, wa[i], '0, acc, lat, oth, er, rd);
            exp_v = exp_q.pop_front();
            total++;
            if ({1'((i % 2)), er, rd} !== exp_v || rd !== wv[i]) begin
                bad++; $display("FAIL edge_readback: addr %h got %h expected %h", wa[i], {1'((i % 2)), er, rd}, exp_v);
            end
        end
    endtask

    task automatic test_errors();
        logic [ACW-1:0] acc; int lat; logic oth, er; logic [DW-1:0] rd; logic [SBW-1:0] exp_v;
        logic [31:0] ba [7];
        ba[0] = 32'h0040_0000; ba[1] = 32'h1001_0002; ba[2] = 32'h7FFF_FFFC;
        ba[3] = 32'h1001_1000; ba[4] = 32'h7FFF_EFF8; ba[5] = 32'h0FFF_FFFC;
        ba[6] = 32'h7FFF_EFFD;
        for (int i = 0; i < 7; i++) begin
            model_txn(i % 2, 1'b0, ba[i], '0);
            run_txn(i % 2, 1'b0, ba[i], '0, acc, lat, oth, er, rd);
            exp_v = exp_q.pop_front();
            total++;
            if (acc[ACW-1 -: 2] !== 2'b00) begin
                bad++; $display("FAIL err_no_access: addr %h got en/we %b expected 00", ba[i], acc[ACW-1 -: 2]);
            end
            total++;
            if (lat !== 3 || {1'((i % 2)), er, rd} !== exp_v) begin
                bad++; $display("FAIL err_resp: addr %h got lat %0d resp %h expected lat 3 resp %h",
                                ba[i], lat, {1'((i % 2)), er, rd}, exp_v);
            end
            total++;
            if (bus.err_count !== 8'(err_exp)) begin
                bad++; $display("FAIL err_count: got %0d expected %0d", bus.err_count, err_exp);
            end
        end
    endtask

    task automatic test_random();
        logic [ACW-1:0] acc; int lat; logic oth, er; logic [DW-1:0] rd; logic [SBW-1:0] exp_v;
        int port; logic we; logic [31:0] a; logic [DW-1:0] wd;
        for (int i = 0; i < 24; i++) begin
            port = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 1) == 1) ? 32'h1001_0000 + $urandom_range(0, 15) * 4
                                               : 32'h7FFF_EFFC + $urandom_range(0, 15) * 4;
            wd   = $urandom;
            model_txn(port, we, a, wd);
            run_txn(port, we, a, wd, acc, lat, oth, er, rd);
            exp_v = exp_q.pop_front();
            total++;
            if ({port[0], er, rd} !== exp_v || lat !== 3) begin
                bad++; $display("FAIL rand_resp: addr %h got lat %0d resp %h expected lat 3 resp %h",
                                a, lat, {port[0], er, rd}, exp_v);
            end
            total++;
            if (acc !== {1'b1, we, exp_phys(a), wd}) begin
                bad++; $display("FAIL rand_access: addr %h got %h expected %h", a, acc, {1'b1, we, exp_phys(a), wd});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [SBW-1:0] obs, exp_v;
        int n;
        apply_reset(2);
        for (int k = 0; k < 2; k++) begin
            model_txn(0, 1'b0, 32'h1001_0020, '0);
            model_txn(1, 1'b0, 32'h7FFF_F000, '0);
        end
        drive_req(0, 1'b0, 32'h1001_0020, '0);
        drive_req(1, 1'b0, 32'h7FFF_F000, '0);
        n = 0;
        for (int c = 1; c <= 20 && n < 4; c++) begin
            @(negedge clk);
            if (bus.ack_0 === 1'b1 || bus.ack_1 === 1'b1) begin
                obs   = bus.ack_1 ? {1'b1, bus.err_1, bus.rdata_1} : {1'b0, bus.err_0, bus.rdata_0};
                exp_v = exp_q.pop_front();
                total++;
                if ((bus.ack_0 & bus.ack_1) !== 1'b0 || obs !== exp_v) begin
                    bad++; $display("FAIL b2b_order: ack %0d got %h expected %h", n, obs, exp_v);
                end
                total++;
                if (c !== 3 * (n + 1)) begin
                    bad++; $display("FAIL b2b_spacing: ack %0d at cycle %0d expected %0d", n, c, 3 * (n + 1));
                end
                n++;
            end
        end
        @(posedge clk);
        #1;
        drop_req(0);
        drop_req(1);
        total++;
        if (n !== 4) begin bad++; $display("FAIL b2b_count: got %0d acks expected 4", n); end
        exp_q.delete();
    endtask

    task automatic test_reset_abort();
        logic [ACW-1:0] acc; int lat; logic oth, er; logic [DW-1:0] rd; logic [SBW-1:0] exp_v;
        int acks;
        drive_req(0, 1'b1, 32'h1001_0040, 32'h1234_5678);
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({bus.mem_en, bus.mem_we, bus.busy} !== 3'b111) begin
            bad++; $display("FAIL abort_pre: got %b expected 111", {bus.mem_en, bus.mem_we, bus.busy});
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.mem_en, bus.mem_we, bus.busy, bus.ack_0} !== 4'b0000) begin
            bad++; $display("FAIL abort_async: got %b expected 0000", {bus.mem_en, bus.mem_we, bus.busy, bus.ack_0});
        end
        total++;
        if (bus.dbg_state !== ST_IDLE) begin
            bad++; $display("FAIL abort_state: got %0d expected %0d", bus.dbg_state, ST_IDLE);
        end
        drop_req(0);
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.ack_0 === 1'b1 || bus.ack_1 === 1'b1) acks++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.ack_0 === 1'b1 || bus.ack_1 === 1'b1) acks++;
        end
        total++;
        if (acks !== 0) begin bad++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks); end
        @(posedge clk);
        #1;
        model_txn(0, 1'b1, 32'h1001_0040, 32'h1234_5678);
        run_txn(0, 1'b1, 32'h1001_0040, 32'h1234_5678, acc, lat, oth, er, rd);
        exp_v = exp_q.pop_front();
        total++;
        if ({1'b0, er, rd} !== exp_v || lat !== 3) begin
            bad++; $display("FAIL abort_reissue: got lat %0d resp %h expected lat 3 resp %h", lat, {1'b0, er, rd}, exp_v);
        end
        model_txn(1, 1'b0, 32'h1001_0040, '0);
        run_txn(1, 1'b0, 32'h1001_0040, '0, acc, lat, oth, er, rd);
        exp_v = exp_q.pop_front();
        total++;
        if ({1'b1, er, rd} !== exp_v || rd !== 32'h1234_5678) begin
            bad++; $display("FAIL abort_readback: got %h expected %h", {1'b1, er, rd}, exp_v);
        end
    endtask

    task automatic test_err_saturate();
        logic [ACW-1:0] acc; int lat; logic oth, er; logic [DW-1:0] rd; logic [SBW-1:0] exp_v;
        int port; logic we; logic [31:0] a;
        for (int i = 0; i < 256; i++) begin
            port = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 32'h0FFF_FFFC))
                                               : (32'h1001_0000 + $urandom_range(0, 32'hFFF)) | 32'h1;
            model_txn(port, we, a, 32'h0);
            run_txn(port, we, a, 32'h0, acc, lat, oth, er, rd);
            exp_v = exp_q.pop_front();
            total++;
            if ({port[0], er, rd} !== exp_v || acc[ACW-1] !== 1'b0) begin
                bad++; $display("FAIL sat_resp: addr %h got en %b resp %h expected en 0 resp %h",
                                a, acc[ACW-1], {port[0], er, rd}, exp_v);
            end
            if (i == 0 || i == 254) begin
                total++;
                if (bus.err_count !== 8'(err_exp)) begin
                    bad++; $display("FAIL sat_count: after %0d got %0d expected %0d", i + 1, bus.err_count, err_exp);
                end
            end
        end
        total++;
        if (bus.err_count !== 8'd255) begin
            bad++; $display("FAIL sat_hold: got %0d expected 255", bus.err_count);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_read();
        test_write();
        test_errors();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_err_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DW, default 32, data word width.
REQ-002 Parameter PAW, default 13, physical RAM address width.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_0 / req_1  in  1  access request, requester 0 (CPU data port) / 1 (DMA).
REQ-006 we_0 / we_1  in  1  1 = write, 0 = read.
REQ-007 addr_0 / addr_1  in  32  virtual byte address.
REQ-008 wdata_0 / wdata_1  in  DW  write data.
REQ-009 ack_0 / ack_1  out  1  one-cycle completion pulse.
REQ-010 err_0 / err_1  out  1  valid with ack; 1 = invalid or misaligned address.
REQ-011 rdata_0 / rdata_1  out  DW  read data, valid from the ack cycle.
REQ-012 mem_en  out  1  RAM access strobe (registered).
REQ-013 mem_we  out  1  RAM write enable (registered).
REQ-014 mem_addr  out  PAW  RAM word address (registered).
REQ-015 mem_wdata  out  DW  RAM write data (registered).
REQ-016 mem_rdata  in  DW  RAM synchronous read data, valid the cycle after mem_en.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 err_count  out  8  saturating count of rejected accesses.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on any req, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-020 Requests sampled only in IDLE; req ignored in ACCESS and RESP.
REQ-021 Arbitration: single request granted directly; both requesting -> grant the requester not served last; last_served pointer updated on every grant, reset value 1 (requester 0 wins first tie).
REQ-022 Address map: [0x7FFFEFFC, 0x7FFFFFFC) -> phys = virt - 0x7FFFEFFC + 0x400; [0x10010000, 0x10011000) -> phys = virt[12:0]; any other address invalid.
REQ-023 addr[1:0] != 0 treated as invalid regardless of window.
REQ-024 Grant latched at IDLE->ACCESS edge: winner index, we, wdata, decoded phys, invalid flag.
REQ-025 In ACCESS: valid access drives mem_en=1, mem_we=we, mem_addr=phys, mem_wdata=wdata for exactly one cycle; invalid access keeps mem_en=0, mem_we=0.
REQ-026 In RESP: ack of winner =1 for one cycle; err = latched invalid flag; for valid reads rdata of winner loads mem_rdata; other requester's outputs unchanged.
REQ-027 Latency fixed: request sampled in cycle N -> ack in cycle N+2, for valid and invalid alike; max throughput one transaction per 3 cycles.
REQ-028 Requester holds req, we, addr, wdata stable until ack and deasserts req the cycle after ack; req still high in that IDLE cycle is a new request.
REQ-029 rdata_k holds its value until the next valid read acknowledged to k; writes and errors leave rdata_k unchanged.
REQ-030 err_count increments by 1 in each RESP with err, saturates at 255, never wraps.
REQ-031 Losing requester is served at the next IDLE if still requesting; no starvation beyond one transaction.

Reset
REQ-032 rst asserted: state IDLE, last_served=1, all ack/err/mem_en/mem_we =0, mem_addr/mem_wdata/rdata_0/rdata_1 =0, err_count=0, busy=0, immediately and asynchronously.
REQ-033 Reset in ACCESS or RESP aborts the transaction: no ack issued, mem_en drops in the same cycle; requester re-issues after release.
REQ-034 First request sampled on the first rising edge after rst deasserts.

Structure
REQ-035 Shared package mem_pkg holds: window base/limit constants, stack offset 0x400, PAW, state enum type.
REQ-036 Combinational decode in one sub-module addr_map (virt in; phys, invalid out), instantiated once on the arbitration-muxed address.

Verification
REQ-037 req_0 read addr_0=0x10010010 alone -> mem_en=1, mem_addr=0x0010 at N+1; ack_0=1, err_0=0, rdata_0=mem_rdata at N+2.
REQ-038 req_1 write addr_1=0x7FFFEFFC, wdata 0xDEADBEEF -> mem_we=1, mem_addr=0x0400, mem_wdata=0xDEADBEEF; ack_1 at N+2.
REQ-039 req_0 read 0x00400000 -> mem_en stays 0; ack_0=1, err_0=1 at N+2; err_count 0->1; 0x10010002 likewise err.
REQ-040 Both requesting continuously after reset -> ack order 0,1,0,1; each ack 3 cycles apart.
REQ-041 rst pulsed during ACCESS of a write -> mem_en low immediately, no ack, busy=0; 256 invalid accesses -> err_count=255 and holds.
